ysyx_22040237_lsu: RTL and testbench

YSYX_22040237_LSU -- requirements
Module: ysyx_22040237_lsu

---
 rtl/ysyx_22040237_lsu_pkg.sv | 56 +++++
 rtl/ysyx_22040237_lsu_if.sv | 23 ++
 rtl/ysyx_22040237_lsu_ext.sv | 26 ++
 rtl/ysyx_22040237_lsu.sv | 150 +++++++++++++++
 tb/tb_ysyx_22040237_lsu.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22040237_lsu_pkg.sv
// Shared definitions for the LSU: ls_info_bus layout, FSM states and access-size helpers.
package ysyx_22040237_lsu_pkg;

    localparam int unsigned LS_BUS_W = 7;

    localparam int unsigned LS_LOAD  = 0;
    localparam int unsigned LS_STORE = 1;
    localparam int unsigned LS_USIGN = 2;
    localparam int unsigned LS_BYTE  = 3;
    localparam int unsigned LS_HALF  = 4;
    localparam int unsigned LS_WORD  = 5;
    localparam int unsigned LS_DW    = 6;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } lsu_state_e;

    // log2 of the access size in bytes
    typedef enum logic [1:0] {
        SzByte = 2'd0,
        SzHalf = 2'd1,
        SzWord = 2'd2,
        SzDw   = 2'd3
    } lsu_size_e;

    function automatic lsu_size_e ls_size(input logic [LS_BUS_W-1:0] ls);
        case (ls[LS_DW:LS_BYTE])
            4'b0001: ls_size = SzByte;
            4'b0010: ls_size = SzHalf;
            4'b0100: ls_size = SzWord;
            default: ls_size = SzDw;
        endcase
    endfunction

    function automatic logic [7:0] size_mask(input lsu_size_e sz);
        case (sz)
            SzByte:  size_mask = 8'h01;
            SzHalf:  size_mask = 8'h03;
            SzWord:  size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

    function automatic logic is_misaligned(input lsu_size_e sz, input logic [2:0] off);
        case (sz)
            SzByte:  is_misaligned = 1'b0;
            SzHalf:  is_misaligned = off[0];
            SzWord:  is_misaligned = |off[1:0];
            default: is_misaligned = |off;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22040237_lsu_if.sv
// Memory request/response bus between the LSU (master) and the memory system (slave).
interface ysyx_22040237_lsu_if #(
    parameter int unsigned REG_WIDTH = 64
) ();
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic [REG_WIDTH-1:0] mem_req_addr;
    logic                 mem_req_wen;
    logic [REG_WIDTH-1:0] mem_req_wdata;
    logic [7:0]           mem_req_wmask;
    logic                 mem_resp_valid;
    logic [REG_WIDTH-1:0] mem_resp_rdata;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata
    );
endinterface

// File: rtl/ysyx_22040237_lsu_ext.sv
// Load data extraction: shift the selected lane down and sign/zero-extend to full width.
module ysyx_22040237_lsu_ext
    import ysyx_22040237_lsu_pkg::*;
#(
    parameter int unsigned REG_WIDTH = 64
) (
    input  logic [REG_WIDTH-1:0] rdata_i,
    input  logic [2:0]           offset_i,
    input  lsu_size_e            size_i,
    input  logic                 usign_i,
    output logic [REG_WIDTH-1:0] result_o
);
    logic [REG_WIDTH-1:0] shifted;

    assign shifted = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        result_o = shifted;
        unique case (size_i)
            SzByte: result_o = {{(REG_WIDTH-8){~usign_i & shifted[7]}}, shifted[7:0]};
            SzHalf: result_o = {{(REG_WIDTH-16){~usign_i & shifted[15]}}, shifted[15:0]};
            SzWord: result_o = {{(REG_WIDTH-32){~usign_i & shifted[31]}}, shifted[31:0]};
            SzDw:   result_o = shifted;
        endcase
    end
endmodule

// File: rtl/ysyx_22040237_lsu.sv
// Load/store unit: passes ALU results through, or issues one aligned bus access per load/store.
module ysyx_22040237_lsu
    import ysyx_22040237_lsu_pkg::*;
#(
    parameter int unsigned REG_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   rd_wr_en_i,
    input  logic [4:0]             rd_idx_i,
    input  logic [REG_WIDTH-1:0]   alu_res_i,
    input  logic [LS_BUS_W-1:0]    ls_info_bus_i,
    input  logic [REG_WIDTH-1:0]   rs2_store_i,
    output logic                   out_valid,
    output logic                   rd_wr_en_o,
    output logic [4:0]             rd_idx_o,
    output logic [REG_WIDTH-1:0]   rd_wdata_o,
    output logic                   misalign_o,
    ysyx_22040237_lsu_if.master    mem
);
    lsu_state_e           state_q, state_d;
    logic [REG_WIDTH-1:0] addr_q, addr_d;
    logic                 wen_q, wen_d;
    logic [REG_WIDTH-1:0] wdata_q, wdata_d;
    logic [7:0]           wmask_q, wmask_d;
    logic [2:0]           offset_q, offset_d;
    lsu_size_e            size_q, size_d;
    logic                 usign_q, usign_d;
    logic                 rd_wr_en_q, rd_wr_en_d;
    logic [4:0]           rd_idx_q, rd_idx_d;
    logic [REG_WIDTH-1:0] rd_wdata_q, rd_wdata_d;
    logic                 misalign_q, misalign_d;
    logic [REG_WIDTH-1:0] ext_data;

    logic       in_load, in_store, in_mem;
    logic [2:0] in_off;
    lsu_size_e  in_size;

    assign in_load  = ls_info_bus_i[LS_LOAD];
    assign in_store = ls_info_bus_i[LS_STORE];
    assign in_mem   = in_load | in_store;
    assign in_off   = alu_res_i[2:0];
    assign in_size  = ls_size(ls_info_bus_i);

    ysyx_22040237_lsu_ext #(.REG_WIDTH(REG_WIDTH)) u_ext (
        .rdata_i  (mem.mem_resp_rdata),
        .offset_i (offset_q),
        .size_i   (size_q),
        .usign_i  (usign_q),
        .result_o (ext_data)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        offset_d   = offset_q;
        size_d     = size_q;
        usign_d    = usign_q;
        rd_wr_en_d = rd_wr_en_q;
        rd_idx_d   = rd_idx_q;
        rd_wdata_d = rd_wdata_q;
        misalign_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    rd_idx_d = rd_idx_i;
                    if (!in_mem) begin
                        rd_wr_en_d = rd_wr_en_i;
                        rd_wdata_d = alu_res_i;
                        state_d    = StDone;
                    end else if (is_misaligned(in_size, in_off)) begin
                        misalign_d = 1'b1;
                        rd_wr_en_d = 1'b0;
                        rd_wdata_d = '0;
                        state_d    = StDone;
                    end else begin
                        addr_d     = {alu_res_i[REG_WIDTH-1:3], 3'b000};
                        wen_d      = in_store;
                        wdata_d    = in_store ? (rs2_store_i << {in_off, 3'b000}) : '0;
                        wmask_d    = in_store ? (size_mask(in_size) << in_off) : 8'h00;
                        offset_d   = in_off;
                        size_d     = in_size;
                        usign_d    = ls_info_bus_i[LS_USIGN];
                        rd_wr_en_d = in_store ? 1'b0 : rd_wr_en_i;
                        rd_wdata_d = '0;
                        state_d    = StReq;
                    end
                end
            end
            StReq: begin
                if (mem.mem_req_ready) state_d = StWait;
            end
            StWait: begin
                if (mem.mem_resp_valid) begin
                    if (!wen_q) rd_wdata_d = ext_data;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= 8'h00;
            offset_q   <= 3'd0;
            size_q     <= SzByte;
            usign_q    <= 1'b0;
            rd_wr_en_q <= 1'b0;
            rd_idx_q   <= 5'd0;
            rd_wdata_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            offset_q   <= offset_d;
            size_q     <= size_d;
            usign_q    <= usign_d;
            rd_wr_en_q <= rd_wr_en_d;
            rd_idx_q   <= rd_idx_d;
            rd_wdata_q <= rd_wdata_d;
            misalign_q <= misalign_d;
        end
    end

    assign in_ready          = (state_q == StIdle);
    assign out_valid         = (state_q == StDone);
    assign rd_wr_en_o        = rd_wr_en_q;
    assign rd_idx_o          = rd_idx_q;
    assign rd_wdata_o        = rd_wdata_q;
    assign misalign_o        = misalign_q;
    assign mem.mem_req_valid = (state_q == StReq);
    assign mem.mem_req_addr  = addr_q;
    assign mem.mem_req_wen   = wen_q;
    assign mem.mem_req_wdata = wdata_q;
    assign mem.mem_req_wmask = wmask_q;
endmodule

// File: tb/tb_ysyx_22040237_lsu.sv
// Directed self-checking bench for ysyx_22040237_lsu.
module tb_ysyx_22040237_lsu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        rd_wr_en_i;
    logic [4:0]  rd_idx_i;
    logic [63:0] alu_res_i;
    logic [6:0]  ls_info_bus_i;
    logic [63:0] rs2_store_i;
    logic        out_valid;
    logic        rd_wr_en_o;
    logic [4:0]  rd_idx_o;
    logic [63:0] rd_wdata_o;
    logic        misalign_o;

    int tests = 0;
    int fails = 0;

    // ls_info_bus encodings: {dw, word, half, byte, usign, store, load}
    localparam logic [6:0] LsAlu = 7'b0000000;
    localparam logic [6:0] LsLb  = 7'b0001001;
    localparam logic [6:0] LsLbu = 7'b0001101;
    localparam logic [6:0] LsSh  = 7'b0010010;
    localparam logic [6:0] LsLw  = 7'b0100001;
    localparam logic [6:0] LsLd  = 7'b1000001;

    ysyx_22040237_lsu_if #(.REG_WIDTH(64)) mem_bus ();

    ysyx_22040237_lsu #(.REG_WIDTH(64)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .rd_wr_en_i    (rd_wr_en_i),
        .rd_idx_i      (rd_idx_i),
        .alu_res_i     (alu_res_i),
        .ls_info_bus_i (ls_info_bus_i),
        .rs2_store_i   (rs2_store_i),
        .out_valid     (out_valid),
        .rd_wr_en_o    (rd_wr_en_o),
        .rd_idx_o      (rd_idx_o),
        .rd_wdata_o    (rd_wdata_o),
        .misalign_o    (misalign_o),
        .mem           (mem_bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [6:0] ls, input logic [63:0] alu, input logic [63:0] rs2,
                         input logic [4:0] idx, input logic wr);
        in_valid      = 1'b1;
        ls_info_bus_i = ls;
        alu_res_i     = alu;
        rs2_store_i   = rs2;
        rd_idx_i      = idx;
        rd_wr_en_i    = wr;
    endtask

    task automatic scramble_inputs();
        in_valid      = 1'b0;
        alu_res_i     = 64'hDEAD_BEEF_CAFE_F00D;
        rs2_store_i   = 64'h0123_4567_89AB_CDEF;
        ls_info_bus_i = LsLd;
        rd_idx_i      = 5'd31;
    endtask

    initial begin
        rst_n                  = 1'b0;
        in_valid               = 1'b0;
        rd_wr_en_i             = 1'b0;
        rd_idx_i               = 5'd0;
        alu_res_i              = '0;
        ls_info_bus_i          = LsAlu;
        rs2_store_i            = '0;
        mem_bus.mem_req_ready  = 1'b0;
        mem_bus.mem_resp_valid = 1'b0;
        mem_bus.mem_resp_rdata = '0;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_req_valid", {63'd0, mem_bus.mem_req_valid}, 64'd0);
        check("rst_rd_wdata", rd_wdata_o, 64'd0);
        check("rst_misalign", {63'd0, misalign_o}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        rst_n = 1'b1;
        tick();

        // ALU passthrough
        issue(LsAlu, 64'h1234, 64'd0, 5'd5, 1'b1);
        tick();
        in_valid = 1'b0;
        check("add_out_valid", {63'd0, out_valid}, 64'd1);
        check("add_wdata", rd_wdata_o, 64'h1234);
        check("add_idx", {59'd0, rd_idx_o}, 64'd5);
        check("add_wr_en", {63'd0, rd_wr_en_o}, 64'd1);
        check("add_in_ready_busy", {63'd0, in_ready}, 64'd0);
        tick();
        check("add_out_valid_drop", {63'd0, out_valid}, 64'd0);

        // LB, sign-extended; ready already high on entry still costs a REQ cycle
        mem_bus.mem_req_ready = 1'b1;
        issue(LsLb, 64'h8000_0003, 64'd0, 5'd10, 1'b1);
        tick();
        scramble_inputs();
        check("lb_req_valid", {63'd0, mem_bus.mem_req_valid}, 64'd1);
        check("lb_req_addr", mem_bus.mem_req_addr, 64'h8000_0000);
        check("lb_req_wen", {63'd0, mem_bus.mem_req_wen}, 64'd0);
        check("lb_req_wmask", {56'd0, mem_bus.mem_req_wmask}, 64'd0);
        tick();
        check("lb_wait_req_valid", {63'd0, mem_bus.mem_req_valid}, 64'd0);
        mem_bus.mem_resp_valid = 1'b1;
        mem_bus.mem_resp_rdata = 64'h0000_0000_8000_0000;
        tick();
        mem_bus.mem_resp_valid = 1'b0;
        check("lb_out_valid", {63'd0, out_valid}, 64'd1);
        check("lb_wdata", rd_wdata_o, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_idx", {59'd0, rd_idx_o}, 64'd10);
        check("lb_wr_en", {63'd0, rd_wr_en_o}, 64'd1);
        tick();

        // LBU, zero-extended
        issue(LsLbu, 64'h8000_0003, 64'd0, 5'd11, 1'b1);
        tick();
        scramble_inputs();
        tick();
        mem_bus.mem_resp_valid = 1'b1;
        mem_bus.mem_resp_rdata = 64'h0000_0000_8000_0000;
        tick();
        mem_bus.mem_resp_valid = 1'b0;
        check("lbu_out_valid", {63'd0, out_valid}, 64'd1);
        check("lbu_wdata", rd_wdata_o, 64'h80);
        tick();

        // SH at offset 6
        mem_bus.mem_req_ready = 1'b0;
        issue(LsSh, 64'h8000_0006, 64'hBEEF, 5'd3, 1'b1);
        tick();
        scramble_inputs();
        check("sh_req_valid", {63'd0, mem_bus.mem_req_valid}, 64'd1);
        check("sh_wmask", {56'd0, mem_bus.mem_req_wmask}, 64'hC0);
        check("sh_wdata", mem_bus.mem_req_wdata, 64'hBEEF_0000_0000_0000);
        check("sh_wen", {63'd0, mem_bus.mem_req_wen}, 64'd1);
        check("sh_addr", mem_bus.mem_req_addr, 64'h8000_0000);
        mem_bus.mem_req_ready = 1'b1;
        tick();
        mem_bus.mem_resp_valid = 1'b1;
        mem_bus.mem_resp_rdata = 64'h5555_5555_5555_5555;
        tick();
        mem_bus.mem_resp_valid = 1'b0;
        check("sh_out_valid", {63'd0, out_valid}, 64'd1);
        check("sh_wr_en", {63'd0, rd_wr_en_o}, 64'd0);
        tick();

        // Misaligned LD
        issue(LsLd, 64'h8000_0004, 64'd0, 5'd7, 1'b1);
        tick();
        in_valid = 1'b0;
        check("ld_misalign", {63'd0, misalign_o}, 64'd1);
        check("ld_out_valid", {63'd0, out_valid}, 64'd1);
        check("ld_no_req", {63'd0, mem_bus.mem_req_valid}, 64'd0);
        check("ld_wr_en", {63'd0, rd_wr_en_o}, 64'd0);
        tick();
        check("ld_misalign_drop", {63'd0, misalign_o}, 64'd0);
        check("ld_out_valid_drop", {63'd0, out_valid}, 64'd0);
        check("ld_no_req2", {63'd0, mem_bus.mem_req_valid}, 64'd0);

        // LW with ready held low for 3 cycles
        mem_bus.mem_req_ready = 1'b0;
        issue(LsLw, 64'h8000_0004, 64'd0, 5'd9, 1'b1);
        tick();
        scramble_inputs();
        for (int c = 0; c < 3; c++) begin
            check("lw_stall_valid", {63'd0, mem_bus.mem_req_valid}, 64'd1);
            check("lw_stall_addr", mem_bus.mem_req_addr, 64'h8000_0000);
            check("lw_stall_wmask", {56'd0, mem_bus.mem_req_wmask}, 64'd0);
            check("lw_stall_wen", {63'd0, mem_bus.mem_req_wen}, 64'd0);
            check("lw_stall_in_ready", {63'd0, in_ready}, 64'd0);
            check("lw_stall_out_valid", {63'd0, out_valid}, 64'd0);
            if (c == 2) mem_bus.mem_req_ready = 1'b1;
            tick();
        end
        check("lw_wait_valid", {63'd0, mem_bus.mem_req_valid}, 64'd0);
        check("lw_wait_in_ready", {63'd0, in_ready}, 64'd0);
        mem_bus.mem_resp_valid = 1'b1;
        mem_bus.mem_resp_rdata = 64'h7654_3210_0000_0000;
        tick();
        mem_bus.mem_resp_valid = 1'b0;
        check("lw_out_valid", {63'd0, out_valid}, 64'd1);
        check("lw_wdata", rd_wdata_o, 64'h0000_0000_7654_3210);
        check("lw_idx", {59'd0, rd_idx_o}, 64'd9);
        tick();
        check("lw_out_valid_drop", {63'd0, out_valid}, 64'd0);

        // Reset asserted while waiting for the response
        issue(LsLw, 64'h8000_0004, 64'd0, 5'd12, 1'b1);
        tick();
        scramble_inputs();
        tick();
        rst_n = 1'b0;
        #1;
        check("rstw_out_valid", {63'd0, out_valid}, 64'd0);
        check("rstw_rd_wdata", rd_wdata_o, 64'd0);
        check("rstw_rd_idx", {59'd0, rd_idx_o}, 64'd0);
        check("rstw_rd_wr_en", {63'd0, rd_wr_en_o}, 64'd0);
        check("rstw_req_addr", mem_bus.mem_req_addr, 64'd0);
        check("rstw_req_valid", {63'd0, mem_bus.mem_req_valid}, 64'd0);
        check("rstw_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        mem_bus.mem_resp_valid = 1'b1;
        mem_bus.mem_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        mem_bus.mem_resp_valid = 1'b0;
        check("stale_out_valid", {63'd0, out_valid}, 64'd0);
        check("stale_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        check("stale_out_valid2", {63'd0, out_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
